or_reduce_pipe: RTL and testbench
=================================

Name: or_reduce_pipe

Overview:
- Parametrised, pipelined successor to the fixed 5-input inverted-input OR cell.
- Reduces WIDTH inputs to one OR result; each input can be inverted individually via a compile-time mask.
- Registered balanced tree with valid tracking, clock enable, sticky event capture and a saturating hit counter.
- Used as a registered wide-OR / any-flag-low detector in status and interrupt logic around the processor core.

Parameters:
- WIDTH, 5, number of inputs (2..64).
- INV_MASK, {WIDTH{1'b1}}, bit i = 1 inverts I[i] before the OR (all-ones reproduces the 5-input inverted-input OR function).
- FANIN, 4, max inputs per OR node per stage (2..8).
- CNT_W, 8, width of saturating hit counter.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- ce  in  1  clock enable; 0 freezes all pipeline, valid, sticky and counter state
- I  in  WIDTH  input vector
- i_valid  in  1  I is meaningful this cycle
- clr  in  1  synchronous clear of sticky and hit_cnt (honoured only when ce=1)
- O  out  1  registered OR result, qualified by o_valid
- o_valid  out  1  O corresponds to an accepted input
- sticky  out  1  set by any valid O=1, held until clr
- hit_cnt  out  CNT_W  count of valid O=1 results, saturates at all-ones

Behaviour:
- Reset (reset_n low, async): O=0, o_valid=0, sticky=0, hit_cnt=0, all pipeline registers and valid bits 0. Deassertion is sampled synchronously by the surrounding design; the block needs no internal synchroniser.
- Input conditioning: X[i] = I[i] XOR INV_MASK[i], combinational, unregistered.
- Tree: S = ceil(log_FANIN(WIDTH)) stages, minimum 1.
  - Each stage ORs groups of up to FANIN bits from the previous stage and registers the result.
  - The last group of a stage may be short; it is padded with 0.
- Latency: exactly S ce-qualified cycles from I/i_valid to O/o_valid. Example: WIDTH=5, FANIN=2 gives S=3; WIDTH=5, FANIN=8 gives S=1.
- Valid pipeline: a 1-bit shift register of depth S advances with the data. With i_valid=0 the data still moves, and O is don't-care while o_valid=0.
- ce=0: every register holds and no stage advances. Throughput is one input per ce cycle, with no bubbles.
- Sticky:
  - Next state = (sticky AND NOT clr) OR (o_valid AND O).
  - A new hit in the same cycle as clr wins, so no event is lost.
- hit_cnt:
  - On clr, the counter loads (o_valid AND O) ? 1 : 0.
  - Otherwise it increments on o_valid AND O and stops at 2^CNT_W-1 (no wrap).
- Reset mid-operation: all in-flight results are discarded, and o_valid stays 0 for S ce-cycles after reset release.
- WIDTH=1: S=1, and the block behaves as a registered buffer or inverter.

Optional Feature:
- Macro OR_REDUCE_HIT_INDEX_EN.
- When defined:
  - Adds output hit_idx, width ceil(log2(WIDTH)) (min 1).
  - hit_idx = index of the lowest i with X[i]=1, computed at the input and carried through S registers aligned with O.
  - hit_idx = 0 when O=0. Reset value 0; held under ce=0.
- When not defined: no port, no extra logic. All other behaviour is identical.

Test Plan:
- Reset/latency: WIDTH=5, INV_MASK=5'b11111, FANIN=2; hold reset_n=0, then I=5'b11111 with i_valid=1 from cycle 0 -> O=0, o_valid=1 at cycle 3. Then I=5'b11011 -> O=1 three cycles later. Before cycle 3: o_valid=0, sticky=0, hit_cnt=0.
- Mask mix: WIDTH=8, INV_MASK=8'h0F, FANIN=4; I=8'h0F -> O=0. I=8'h1F -> O=1. I=8'h0E -> O=1 (bit0 inverted). Each response arrives after 2 cycles.
- ce stall: stream 8'h0F, 8'h1F, 8'h0F and drop ce for 3 cycles mid-stream -> outputs 0, 1, 0 arrive in order with no duplication or loss, and all state is frozen while ce=0.
- Sticky/clr collision: produce a valid O=1 in the same cycle as clr=1 with hit_cnt=5 -> next cycle sticky=1, hit_cnt=1. Then clr alone -> sticky=0, hit_cnt=0.
- Saturation: CNT_W=3; 10 consecutive valid hits -> hit_cnt reaches 7 and stays at 7.
- Async reset mid-flight plus index feature (macro defined): WIDTH=5, INV_MASK=0, I=5'b10100 -> hit_idx=2 with O=1. Assert reset_n low between clock edges while data is in flight -> O, o_valid, sticky, hit_cnt and hit_idx go to 0 immediately; o_valid stays 0 for 3 cycles after release.

Source files
------------

// File: rtl/or_reduce_pipe.sv
// Registered wide-OR with per-input inversion, valid tracking, sticky event flag and saturating hit counter.
// Defining OR_REDUCE_HIT_INDEX_EN adds hit_idx, the lowest asserted conditioned-input index, aligned with O.
module or_reduce_pipe #(
   parameter int               WIDTH    = 5,
   parameter logic [WIDTH-1:0] INV_MASK = {WIDTH{1'b1}},
   parameter int               FANIN    = 4,
   parameter int               CNT_W    = 8,
   localparam int              IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             ce,
   input  logic [WIDTH-1:0] I,
   input  logic             i_valid,
   input  logic             clr,
   output logic             O,
   output logic             o_valid,
   output logic             sticky,
   output logic [CNT_W-1:0] hit_cnt
`ifdef OR_REDUCE_HIT_INDEX_EN
   ,
   output logic [IDX_W-1:0] hit_idx
`endif
);

   // Number of nodes feeding stage k (k=0 is the conditioned input vector).
   function automatic int lvl_w(input int k);
      int n;
      n = WIDTH;
      for (int i = 0; i < k; i++) n = (n + FANIN - 1) / FANIN;
      return n;
   endfunction

   function automatic int num_stages();
      int n;
      int s;
      n = (WIDTH + FANIN - 1) / FANIN;
      s = 1;
      while (n > 1) begin
         n = (n + FANIN - 1) / FANIN;
         s++;
      end
      return s;
   endfunction

   localparam int S = num_stages();

   logic [WIDTH-1:0] x;
   assign x = I ^ INV_MASK;

   // Each stage zero-pads its input to a whole number of FANIN groups, so a short last group ORs in zeros.
   for (genvar k = 0; k < S; k++) begin : g_stage
      localparam int NI = lvl_w(k);
      localparam int NO = lvl_w(k + 1);
      localparam int PW = NO * FANIN;
      logic [NI-1:0] in_w;
      logic [PW-1:0] pad;
      logic [NO-1:0] node_d;
      logic [NO-1:0] node_q;

      if (k == 0) begin : g_first
         assign in_w = x;
      end else begin : g_next
         assign in_w = g_stage[k-1].node_q;
      end

      assign pad = PW'(in_w);

      for (genvar j = 0; j < NO; j++) begin : g_node
         assign node_d[j] = |pad[j*FANIN +: FANIN];
      end

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n)  node_q <= '0;
         else if (ce)   node_q <= node_d;
      end
   end

   logic [S-1:0] vld_d;
   logic [S-1:0] vld_q;

   always_comb begin
      vld_d    = '0;
      vld_d[0] = i_valid;
      for (int k = 1; k < S; k++) vld_d[k] = vld_q[k-1];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  vld_q <= '0;
      else if (ce)   vld_q <= vld_d;
   end

   assign O       = g_stage[S-1].node_q[0];
   assign o_valid = vld_q[S-1];

   logic             hit;
   logic             sticky_d;
   logic             sticky_q;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_q;

   assign hit = o_valid & O;

   // A hit landing in the clear cycle survives, so no event is lost across clr.
   always_comb begin
      sticky_d = (sticky_q & ~clr) | hit;
      cnt_d    = cnt_q;
      if (clr)                     cnt_d = hit ? CNT_W'(1) : '0;
      else if (hit && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sticky_q <= 1'b0;
         cnt_q    <= '0;
      end else if (ce) begin
         sticky_q <= sticky_d;
         cnt_q    <= cnt_d;
      end
   end

   assign sticky  = sticky_q;
   assign hit_cnt = cnt_q;

`ifdef OR_REDUCE_HIT_INDEX_EN
   logic [IDX_W-1:0] first_idx;
   logic [IDX_W-1:0] idx_d [S];
   logic [IDX_W-1:0] idx_q [S];

   // Scan downward so the lowest set index wins; all-zero input leaves 0, matching O=0.
   always_comb begin
      first_idx = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (x[i]) first_idx = IDX_W'(i);
      end
   end

   always_comb begin
      for (int k = 0; k < S; k++) idx_d[k] = '0;
      idx_d[0] = first_idx;
      for (int k = 1; k < S; k++) idx_d[k] = idx_q[k-1];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < S; k++) idx_q[k] <= '0;
      end else if (ce) begin
         for (int k = 0; k < S; k++) idx_q[k] <= idx_d[k];
      end
   end

   assign hit_idx = idx_q[S-1];
`endif

endmodule

// File: tb/tb_or_reduce_pipe.sv
// Scoreboard bench for or_reduce_pipe: three configurations driven with directed vectors,
// expected responses queued at issue time and popped by per-instance output monitors.
module tb_or_reduce_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n;

   // a: WIDTH=5, all-ones mask, FANIN=2 (3 stages)
   logic       ce_a, v_a, clr_a, o_a, ov_a, st_a;
   logic [4:0] in_a;
   logic [7:0] cnt_a;
   logic [2:0] idx_a;
   // b: WIDTH=8, mask 0F, FANIN=4 (2 stages), 3-bit counter
   logic       ce_b, v_b, clr_b, o_b, ov_b, st_b;
   logic [7:0] in_b;
   logic [2:0] cnt_b;
   logic [2:0] idx_b;
   // c: WIDTH=5, no inversion, FANIN=2 (3 stages)
   logic       ce_c, v_c, clr_c, o_c, ov_c, st_c;
   logic [4:0] in_c;
   logic [7:0] cnt_c;
   logic [2:0] idx_c;

   or_reduce_pipe #(.WIDTH(5), .INV_MASK(5'b11111), .FANIN(2), .CNT_W(8)) u_a (
      .clk(clk), .reset_n(reset_n), .ce(ce_a), .I(in_a), .i_valid(v_a), .clr(clr_a),
      .O(o_a), .o_valid(ov_a), .sticky(st_a), .hit_cnt(cnt_a)
`ifdef OR_REDUCE_HIT_INDEX_EN
      , .hit_idx(idx_a)
`endif
   );

   or_reduce_pipe #(.WIDTH(8), .INV_MASK(8'h0F), .FANIN(4), .CNT_W(3)) u_b (
      .clk(clk), .reset_n(reset_n), .ce(ce_b), .I(in_b), .i_valid(v_b), .clr(clr_b),
      .O(o_b), .o_valid(ov_b), .sticky(st_b), .hit_cnt(cnt_b)
`ifdef OR_REDUCE_HIT_INDEX_EN
      , .hit_idx(idx_b)
`endif
   );

   or_reduce_pipe #(.WIDTH(5), .INV_MASK(5'b00000), .FANIN(2), .CNT_W(8)) u_c (
      .clk(clk), .reset_n(reset_n), .ce(ce_c), .I(in_c), .i_valid(v_c), .clr(clr_c),
      .O(o_c), .o_valid(ov_c), .sticky(st_c), .hit_cnt(cnt_c)
`ifdef OR_REDUCE_HIT_INDEX_EN
      , .hit_idx(idx_c)
`endif
   );

`ifndef OR_REDUCE_HIT_INDEX_EN
   initial begin
      idx_a = '0;
      idx_b = '0;
      idx_c = '0;
   end
`endif

   int checks   = 0;
   int failures = 0;

   logic [0:0] exp_a_q[$];
   logic [0:0] exp_b_q[$];
   logic [3:0] exp_c_q[$];  // {hit_idx, O}
   logic [0:0] e_a, e_b;
   logic [3:0] e_c;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h, required %0h", nm, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic [4:0] v, input logic e);
      in_a = v; v_a = 1'b1; exp_a_q.push_back(e);
   endtask

   task automatic drive_b(input logic [7:0] v, input logic e);
      in_b = v; v_b = 1'b1; exp_b_q.push_back(e);
   endtask

   // Monitors: an output is consumed once per ce-qualified cycle in which o_valid is high.
   always @(negedge clk) begin
      if (reset_n && ce_a && ov_a) begin
         if (exp_a_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL a_out: got unexpected output O=%0b, required none", o_a);
         end else begin
            e_a = exp_a_q.pop_front();
            chk("a_out", o_a, e_a);
         end
      end
      if (reset_n && ce_b && ov_b) begin
         if (exp_b_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL b_out: got unexpected output O=%0b, required none", o_b);
         end else begin
            e_b = exp_b_q.pop_front();
            chk("b_out", o_b, e_b);
         end
      end
      if (reset_n && ce_c && ov_c) begin
         if (exp_c_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL c_out: got unexpected output O=%0b, required none", o_c);
         end else begin
            e_c = exp_c_q.pop_front();
`ifdef OR_REDUCE_HIT_INDEX_EN
            chk("c_out_idx_o", {idx_c, o_c}, e_c);
`else
            chk("c_out", o_c, e_c[0]);
`endif
         end
      end
   end

   logic [4:0] c_vec [7] = '{5'b00001, 5'b10000, 5'b00000, 5'b11000, 5'b10100, 5'b10100, 5'b10100};
   logic [3:0] c_exp [7] = '{4'b0001, 4'b1001, 4'b0000, 4'b0111, 4'b0101, 4'b0101, 4'b0101};

   initial begin
      reset_n = 1'b0;
      ce_a = 1'b1; v_a = 1'b0; clr_a = 1'b0; in_a = '0;
      ce_b = 1'b1; v_b = 1'b0; clr_b = 1'b0; in_b = '0;
      ce_c = 1'b1; v_c = 1'b0; clr_c = 1'b0; in_c = '0;
      repeat (3) step();

      chk("rst_a_o", o_a, 0);   chk("rst_a_ov", ov_a, 0);
      chk("rst_a_st", st_a, 0); chk("rst_a_cnt", cnt_a, 0);
      chk("rst_b_ov", ov_b, 0); chk("rst_b_cnt", cnt_b, 0);
      chk("rst_c_ov", ov_c, 0); chk("rst_c_st", st_c, 0);

      // Latency on the 5-input inverted-OR configuration.
      reset_n = 1'b1;
      drive_a(5'b11111, 1'b0); step();
      chk("a_lat1_ov", ov_a, 0); chk("a_lat1_st", st_a, 0); chk("a_lat1_cnt", cnt_a, 0);
      drive_a(5'b11011, 1'b1); step();
      chk("a_lat2_ov", ov_a, 0); chk("a_lat2_cnt", cnt_a, 0);
      drive_a(5'b01111, 1'b1); step();
      chk("a_lat3_ov", ov_a, 1); chk("a_lat3_o", o_a, 0);
      drive_a(5'b11110, 1'b1); step();
      drive_a(5'b00000, 1'b1); step();
      drive_a(5'b11111, 1'b0); step();
      v_a = 1'b0;
      repeat (4) step();
      chk("a_sticky", st_a, 1); chk("a_hits", cnt_a, 4);

      // Mask mix.
      drive_b(8'h0F, 1'b0); step();
      drive_b(8'h1F, 1'b1); step();
      chk("b_lat2_ov", ov_b, 1);
      drive_b(8'h0E, 1'b1); step();
      v_b = 1'b0;
      repeat (3) step();
      chk("b_mix_cnt", cnt_b, 2);

      // Clock-enable stall mid-stream.
      drive_b(8'h0F, 1'b0); step();
      drive_b(8'h1F, 1'b1); step();
      in_b = 8'h0F; ce_b = 1'b0;
      repeat (3) step();
      chk("b_stall_ov", ov_b, 1); chk("b_stall_o", o_b, 0);
      chk("b_stall_st", st_b, 1); chk("b_stall_cnt", cnt_b, 2);
      ce_b = 1'b1;
      drive_b(8'h0F, 1'b0); step();
      v_b = 1'b0;
      repeat (3) step();
      chk("b_stall_after_cnt", cnt_b, 3);

      // Clear, then a hit colliding with clr.
      clr_b = 1'b1; step(); clr_b = 1'b0;
      chk("b_clr0_st", st_b, 0); chk("b_clr0_cnt", cnt_b, 0);
      for (int i = 0; i < 6; i++) begin
         drive_b(8'h1F, 1'b1); step();
      end
      v_b = 1'b0;
      step();
      chk("b_pre_clr_cnt", cnt_b, 5); chk("b_pre_clr_hit", {ov_b, o_b}, 2'b11);
      clr_b = 1'b1; step(); clr_b = 1'b0;
      chk("b_coll_st", st_b, 1); chk("b_coll_cnt", cnt_b, 1);
      clr_b = 1'b1; step(); clr_b = 1'b0;
      chk("b_clr_st", st_b, 0); chk("b_clr_cnt", cnt_b, 0);

      // Saturation of the 3-bit counter.
      for (int i = 0; i < 10; i++) begin
         drive_b(8'h1F, 1'b1); step();
      end
      v_b = 1'b0;
      repeat (3) step();
      chk("b_sat_cnt", cnt_b, 7); chk("b_sat_st", st_b, 1);

      // Index tracking and asynchronous reset with data in flight.
      for (int i = 0; i < 7; i++) begin
         in_c = c_vec[i]; v_c = 1'b1; exp_c_q.push_back(c_exp[i]);
         step();
      end
      chk("c_pre_rst_ov", ov_c, 1); chk("c_pre_rst_o", o_c, 1); chk("c_pre_rst_st", st_c, 1);
`ifdef OR_REDUCE_HIT_INDEX_EN
      chk("c_pre_rst_idx", idx_c, 2);
`endif
      #3;
      reset_n = 1'b0;
      exp_c_q.delete();
      #1;
      chk("c_rst_o", o_c, 0);   chk("c_rst_ov", ov_c, 0);
      chk("c_rst_st", st_c, 0); chk("c_rst_cnt", cnt_c, 0);
      chk("b_rst_cnt", cnt_b, 0);
`ifdef OR_REDUCE_HIT_INDEX_EN
      chk("c_rst_idx", idx_c, 0);
`endif
      step();
      reset_n = 1'b1;
      in_c = 5'b00001; v_c = 1'b1; exp_c_q.push_back(4'b0001);
      step();
      v_c = 1'b0;
      chk("c_rel1_ov", ov_c, 0);
      step();
      chk("c_rel2_ov", ov_c, 0);
      step();
      chk("c_rel3_ov", ov_c, 1); chk("c_rel3_o", o_c, 1);
      repeat (3) step();

      chk("a_queue_drained", exp_a_q.size(), 0);
      chk("b_queue_drained", exp_b_q.size(), 0);
      chk("c_queue_drained", exp_c_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
